// File: rtl/data_loader_sync.sv
// data_loader_sync: buffers matching APF bridge writes in a FIFO and replays each
// one as a run of 8- or 16-bit memory writes with a configurable idle gap.
module data_loader_sync #(
  parameter logic [3:0] ADDRESS_MASK_UPPER_4 = 4'h0,
  parameter int ADDRESS_SIZE = 28,
  parameter int WRITE_MEM_CLOCK_DELAY = 1,
  parameter int OUTPUT_WORD_SIZE = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic clk_74a,
  input  logic reset_n,
  input  logic bridge_wr,
  input  logic bridge_endian_little,
  input  logic [31:0] bridge_addr,
  input  logic [31:0] bridge_wr_data,
  output logic write_en,
  output logic [ADDRESS_SIZE-1:0] write_addr,
  output logic [8*OUTPUT_WORD_SIZE-1:0] write_data,
  output logic busy,
  output logic overflow
);
  localparam int N = 4 / OUTPUT_WORD_SIZE;
  localparam int W = 8 * OUTPUT_WORD_SIZE;
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, WRITE, GAP} state_t;
  state_t state, state_n;
  logic prev_bridge_wr, tx, push, pop, en_n;
  logic [31:0] norm, shift_reg;
  logic [27:0] entry_addr;
  logic [59:0] mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0] count;
  logic [2:0] k;
  logic [3:0] gap_cnt;
  assign tx = bridge_wr & ~prev_bridge_wr & (bridge_addr[31:28] == ADDRESS_MASK_UPPER_4);
  assign norm = bridge_endian_little ? bridge_wr_data
              : {bridge_wr_data[7:0], bridge_wr_data[15:8], bridge_wr_data[23:16], bridge_wr_data[31:24]};
  assign pop = (state == IDLE) && (count != '0);
  // a full FIFO still accepts when the drain side frees a slot in the same cycle
  assign push = tx && ((count != (AW+1)'(FIFO_DEPTH)) || pop);
  always_comb begin
    state_n = state;
    en_n = 1'b0;
    if (pop) state_n = WRITE;
    if (state == WRITE) begin
      en_n = 1'b1;
      state_n = WRITE_MEM_CLOCK_DELAY == 0 ? (k == 3'(N - 1) ? IDLE : WRITE) : GAP;
    end
    // k has already advanced past the sub-word just written
    if (state == GAP && gap_cnt == 4'(WRITE_MEM_CLOCK_DELAY - 1)) state_n = k == 3'(N) ? IDLE : WRITE;
  end
  always_ff @(posedge clk_74a) begin
    if (!reset_n) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk_74a) begin
    if (push) mem[wr_ptr] <= {bridge_addr[27:0], norm};
  end
  always_ff @(posedge clk_74a) begin
    if (!reset_n) begin
      prev_bridge_wr <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      overflow <= 1'b0;
      busy <= 1'b0;
      write_en <= 1'b0;
      write_addr <= '0;
      write_data <= '0;
      entry_addr <= '0;
      shift_reg <= '0;
      k <= '0;
      gap_cnt <= '0;
    end else begin
      prev_bridge_wr <= bridge_wr;
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      overflow <= overflow | (tx & ~push);
      busy <= (count != '0) || (state != IDLE);
      write_en <= en_n;
      if (pop) begin
        {entry_addr, shift_reg} <= mem[rd_ptr];
        k <= '0;
      end
      if (state == WRITE) begin
        write_addr <= ADDRESS_SIZE'(entry_addr + 28'(k * OUTPUT_WORD_SIZE));
        write_data <= shift_reg[W-1:0];
        shift_reg <= shift_reg >> W;
        k <= k + 3'd1;
        gap_cnt <= '0;
      end
      if (state == GAP) gap_cnt <= gap_cnt + 4'd1;
    end
  end
endmodule

// File: tb/tb_data_loader_sync.sv
// tb_data_loader_sync: three differently configured loaders share one bridge and are
// scored against a transaction-level schedule model plus directed scenario checks.
module tb_data_loader_sync;
  logic clk_74a = 1'b0;
  logic reset_n = 1'b0;
  logic bridge_wr = 1'b0;
  logic bridge_endian_little = 1'b1;
  logic [31:0] bridge_addr = '0;
  logic [31:0] bridge_wr_data = '0;
  logic [2:0] en, bz, of;
  logic [27:0] wa [3];
  logic [15:0] wd [3];
  logic [7:0] wd0, wd2;
  logic [15:0] wd1;
  int n_cmp = 0, n_bad = 0, ed = 0;
  bit mprev = 0;
  typedef struct { int e; logic [27:0] a; logic [15:0] d; } pulse_t;
  pulse_t eq [3][$];
  int sq [3][$];
  int nf [3];
  bit ovf [3];
  logic [27:0] la [3];
  logic [15:0] ld [3];
  int obs [3];
  logic [27:0] cap_a [3][32];
  logic [15:0] cap_d [3][32];
  int cap_e [3][32];

  always #5 clk_74a = ~clk_74a;

  data_loader_sync #(.WRITE_MEM_CLOCK_DELAY(1), .OUTPUT_WORD_SIZE(1), .FIFO_DEPTH(4)) u0 (
    .clk_74a(clk_74a), .reset_n(reset_n), .bridge_wr(bridge_wr), .bridge_endian_little(bridge_endian_little),
    .bridge_addr(bridge_addr), .bridge_wr_data(bridge_wr_data), .write_en(en[0]), .write_addr(wa[0]),
    .write_data(wd0), .busy(bz[0]), .overflow(of[0]));
  data_loader_sync #(.WRITE_MEM_CLOCK_DELAY(0), .OUTPUT_WORD_SIZE(2), .FIFO_DEPTH(2)) u1 (
    .clk_74a(clk_74a), .reset_n(reset_n), .bridge_wr(bridge_wr), .bridge_endian_little(bridge_endian_little),
    .bridge_addr(bridge_addr), .bridge_wr_data(bridge_wr_data), .write_en(en[1]), .write_addr(wa[1]),
    .write_data(wd1), .busy(bz[1]), .overflow(of[1]));
  data_loader_sync #(.WRITE_MEM_CLOCK_DELAY(3), .OUTPUT_WORD_SIZE(1), .FIFO_DEPTH(4)) u2 (
    .clk_74a(clk_74a), .reset_n(reset_n), .bridge_wr(bridge_wr), .bridge_endian_little(bridge_endian_little),
    .bridge_addr(bridge_addr), .bridge_wr_data(bridge_wr_data), .write_en(en[2]), .write_addr(wa[2]),
    .write_data(wd2), .busy(bz[2]), .overflow(of[2]));
  assign wd[0] = {8'h00, wd0};
  assign wd[1] = wd1;
  assign wd[2] = {8'h00, wd2};

  function automatic int ows(int i); return i == 1 ? 2 : 1; endfunction
  function automatic int dly(int i); return i == 1 ? 0 : (i == 2 ? 3 : 1); endfunction
  function automatic int dep(int i); return i == 1 ? 2 : 4; endfunction
  function automatic logic [31:0] norm(input logic [31:0] d, input logic le);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = le ? d[8*b +: 8] : d[8*(3-b) +: 8];
    return r;
  endfunction

  // Schedule model: an entry is popped at the later of (push+1) and the end of the
  // previous entry; each of its sub-words then lands every 1+delay cycles.
  always @(posedge clk_74a) begin
    logic tx;
    logic [31:0] nd;
    int s, cnt;
    bit popnow, xp;
    pulse_t p;
    ed++;
    tx = reset_n && bridge_wr && !mprev && bridge_addr[31:28] == 4'h0;
    mprev = reset_n && bridge_wr;
    nd = norm(bridge_wr_data, bridge_endian_little);
    for (int i = 0; i < 3; i++) begin
      if (!reset_n) begin
        eq[i].delete(); sq[i].delete(); nf[i] = 0; ovf[i] = 0; la[i] = '0; ld[i] = '0;
      end else if (tx) begin
        while (sq[i].size() > 0 && sq[i][0] < ed) void'(sq[i].pop_front());
        cnt = sq[i].size();
        popnow = cnt > 0 && sq[i][0] == ed;
        if (cnt < dep(i) || popnow) begin
          s = nf[i] > ed + 1 ? nf[i] : ed + 1;
          nf[i] = s + (4 / ows(i)) * (1 + dly(i)) + 1;
          sq[i].push_back(s);
          for (int j = 0; j < 4 / ows(i); j++) begin
            p.e = s + 1 + j * (1 + dly(i));
            p.a = bridge_addr[27:0] + 28'(j * ows(i));
            p.d = ows(i) == 1 ? {8'h00, nd[8*j +: 8]} : nd[16*j +: 16];
            eq[i].push_back(p);
          end
        end else ovf[i] = 1;
      end
    end
    #1;
    for (int i = 0; i < 3; i++) begin
      xp = eq[i].size() > 0 && eq[i][0].e == ed;
      if (xp) begin
        la[i] = eq[i][0].a; ld[i] = eq[i][0].d; void'(eq[i].pop_front());
      end
      n_cmp++; if (en[i] !== xp) begin n_bad++; $display("FAIL mon_en u%0d edge %0d: got %b want %b", i, ed, en[i], xp); end
      n_cmp++; if (wa[i] !== la[i]) begin n_bad++; $display("FAIL mon_addr u%0d edge %0d: got %h want %h", i, ed, wa[i], la[i]); end
      n_cmp++; if (wd[i] !== ld[i]) begin n_bad++; $display("FAIL mon_data u%0d edge %0d: got %h want %h", i, ed, wd[i], ld[i]); end
      n_cmp++; if (of[i] !== ovf[i]) begin n_bad++; $display("FAIL mon_ovf u%0d edge %0d: got %b want %b", i, ed, of[i], ovf[i]); end
      if (en[i] === 1'b1) begin
        if (obs[i] < 32) begin cap_a[i][obs[i]] = wa[i]; cap_d[i][obs[i]] = wd[i]; cap_e[i][obs[i]] = ed; end
        obs[i]++;
      end
    end
  end

  task automatic bwrite(input logic [31:0] a, input logic [31:0] d, input logic le);
    @(negedge clk_74a);
    bridge_wr = 1'b1; bridge_addr = a; bridge_wr_data = d; bridge_endian_little = le;
    @(negedge clk_74a);
    bridge_wr = 1'b0;
  endtask

  task automatic clear_obs();
    for (int i = 0; i < 3; i++) obs[i] = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (eq[0].size() + eq[1].size() + eq[2].size() != 0 && n < 3000) begin @(negedge clk_74a); n++; end
    n_cmp++;
    if (n >= 3000) begin n_bad++; $display("FAIL wait_idle: got %0d writes outstanding, want 0", eq[0].size() + eq[1].size() + eq[2].size()); end
    repeat (8) @(negedge clk_74a);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk_74a);
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if ({en[i], bz[i], of[i]} !== 3'b000 || wa[i] !== '0 || wd[i] !== '0) begin
        n_bad++; $display("FAIL reset u%0d: got en=%b busy=%b ovf=%b addr=%h data=%h want all 0", i, en[i], bz[i], of[i], wa[i], wd[i]);
      end
    end
    reset_n = 1'b1;
    repeat (2) @(negedge clk_74a);
  endtask

  task automatic test_byte_order(input logic le);
    logic [31:0] w;
    int lat = 0;
    w = le ? 32'h11223344 : 32'h44332211;
    clear_obs();
    bwrite(32'h0000_0100, 32'h11223344, le);
    while (lat < 20) begin
      lat++;
      @(posedge clk_74a); #1;
      if (en[0]) break;
    end
    n_cmp++; if (lat != 2) begin n_bad++; $display("FAIL latency le=%b: got %0d want 2", le, lat); end
    n_cmp++; if (bz[0] !== 1'b1) begin n_bad++; $display("FAIL busy_drain le=%b: got %b want 1", le, bz[0]); end
    wait_idle();
    n_cmp++; if (obs[0] != 4) begin n_bad++; $display("FAIL byte_count le=%b: got %0d want 4", le, obs[0]); end
    for (int j = 0; j < 4; j++) begin
      n_cmp++;
      if (cap_a[0][j] !== 28'(32'h100 + j) || cap_d[0][j] !== {8'h00, w[8*j +: 8]}) begin
        n_bad++; $display("FAIL byte_write%0d le=%b: got %h@%h want %h@%h", j, le, cap_d[0][j], cap_a[0][j], w[8*j +: 8], 32'h100 + j);
      end
      if (j > 0) begin
        n_cmp++; if (cap_e[0][j] - cap_e[0][j-1] != 2) begin n_bad++; $display("FAIL spacing%0d le=%b: got %0d want 2", j, le, cap_e[0][j] - cap_e[0][j-1]); end
      end
    end
    n_cmp++; if (bz !== 3'b000) begin n_bad++; $display("FAIL busy_idle le=%b: got %b want 000", le, bz); end
  endtask

  task automatic test_word();
    clear_obs();
    bwrite(32'h0000_0200, 32'hAABBCCDD, 1'b1);
    wait_idle();
    n_cmp++; if (obs[1] != 2) begin n_bad++; $display("FAIL word_count: got %0d want 2", obs[1]); end
    n_cmp++; if (cap_a[1][0] !== 28'h200 || cap_d[1][0] !== 16'hCCDD) begin n_bad++; $display("FAIL word0: got %h@%h want ccdd@200", cap_d[1][0], cap_a[1][0]); end
    n_cmp++; if (cap_a[1][1] !== 28'h202 || cap_d[1][1] !== 16'hAABB) begin n_bad++; $display("FAIL word1: got %h@%h want aabb@202", cap_d[1][1], cap_a[1][1]); end
  endtask

  task automatic test_filter();
    clear_obs();
    bwrite(32'h1000_0000, 32'hDEADBEEF, 1'b1);
    repeat (20) begin
      @(posedge clk_74a); #1;
      n_cmp++; if (bz !== 3'b000) begin n_bad++; $display("FAIL filter_busy: got %b want 000", bz); end
    end
    n_cmp++; if (obs[0] + obs[1] + obs[2] != 0) begin n_bad++; $display("FAIL filter_writes: got %0d want 0", obs[0] + obs[1] + obs[2]); end
    @(negedge clk_74a);
    bridge_wr = 1'b1; bridge_addr = '0; bridge_wr_data = 32'h0badf00d; bridge_endian_little = 1'b1;
    repeat (10) @(negedge clk_74a);
    bridge_wr = 1'b0;
    wait_idle();
    n_cmp++; if (obs[0] != 4 || obs[1] != 2 || obs[2] != 4) begin n_bad++; $display("FAIL held_strobe: got %0d/%0d/%0d want 4/2/4", obs[0], obs[1], obs[2]); end
  endtask

  task automatic test_overflow();
    logic [31:0] d [6];
    clear_obs();
    for (int j = 0; j < 6; j++) begin
      d[j] = $urandom;
      bwrite(32'h300 + 32'(4 * j), d[j], 1'b1);
    end
    wait_idle();
    n_cmp++; if (obs[2] != 20) begin n_bad++; $display("FAIL ovf_count: got %0d want 20", obs[2]); end
    for (int j = 0; j < 5; j++) begin
      n_cmp++;
      if (cap_a[2][4*j] !== 28'(32'h300 + 4 * j) || cap_d[2][4*j] !== {8'h00, d[j][7:0]}) begin
        n_bad++; $display("FAIL ovf_order%0d: got %h@%h want %h@%h", j, cap_d[2][4*j], cap_a[2][4*j], d[j][7:0], 32'h300 + 4 * j);
      end
    end
    repeat (5) @(negedge clk_74a);
    n_cmp++; if (of[2] !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky: got %b want 1", of[2]); end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    clear_obs();
    bwrite(32'h0000_0400, 32'h55667788, 1'b1);
    while (obs[0] < 2 && n < 50) begin @(negedge clk_74a); n++; end
    n_cmp++; if (obs[0] != 2) begin n_bad++; $display("FAIL mid_reach: got %0d writes want 2", obs[0]); end
    reset_n = 1'b0;
    @(posedge clk_74a); #1;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if ({en[i], bz[i], of[i]} !== 3'b000 || wa[i] !== '0 || wd[i] !== '0) begin
        n_bad++; $display("FAIL mid_reset u%0d: got en=%b busy=%b ovf=%b addr=%h data=%h want all 0", i, en[i], bz[i], of[i], wa[i], wd[i]);
      end
    end
    @(negedge clk_74a);
    reset_n = 1'b1;
    clear_obs();
    bwrite(32'h0, 32'h04030201, 1'b1);
    wait_idle();
    n_cmp++; if (obs[0] != 4) begin n_bad++; $display("FAIL post_reset_count: got %0d want 4", obs[0]); end
    for (int j = 0; j < 4; j++) begin
      n_cmp++;
      if (cap_a[0][j] !== 28'(j) || cap_d[0][j] !== 16'(j + 1)) begin
        n_bad++; $display("FAIL post_reset%0d: got %h@%h want %h@%h", j, cap_d[0][j], cap_a[0][j], j + 1, j);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int n = 0; n < 150; n++) begin
      a = {4'h0, $urandom_range(0, 3) == 0 ? 28'hFFFFFFE : 28'($urandom)};
      if ($urandom_range(0, 7) == 0) a = $urandom;
      bwrite(a, $urandom, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 13)) @(negedge clk_74a);
      if ($urandom_range(0, 40) == 0) begin
        reset_n = 1'b0;
        @(negedge clk_74a);
        reset_n = 1'b1;
      end
    end
    wait_idle();
    n_cmp++; if (bz !== 3'b000) begin n_bad++; $display("FAIL random_idle_busy: got %b want 000", bz); end
  endtask

  initial begin
    test_reset();
    test_byte_order(1'b1);
    test_byte_order(1'b0);
    test_word();
    test_filter();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
